// File: rtl/icache_dm_readonly.sv
// icache_dm_readonly: direct-mapped read-only instruction cache with one-line refill
module icache_dm_readonly #(
    parameter int INDEX_W = 3,
    localparam int TAG_W = 28 - INDEX_W,
    localparam int LINES = 2 ** INDEX_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         proc_read,
    input  logic         proc_write,
    input  logic [29:0]  proc_addr,
    input  logic [31:0]  proc_wdata,
    output logic         proc_stall,
    output logic [31:0]  proc_rdata,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready
);
    typedef enum logic {IDLE, ALLOCATE} state_t;
    state_t state_q, state_d;
    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q [LINES];
    logic [127:0] data_q [LINES];
    logic [INDEX_W-1:0] idx, fill_idx;
    logic [TAG_W-1:0] tag;
    logic hit, miss, fill;
    logic unused_ok;
    assign idx = proc_addr[2+INDEX_W-1:2];
    assign tag = proc_addr[29:2+INDEX_W];
    assign fill_idx = mem_addr[INDEX_W-1:0];
    assign hit = valid_q[idx] && tag_q[idx] == tag;
    assign proc_rdata = data_q[idx][{proc_addr[1:0], 5'd0} +: 32];
    assign mem_write = 1'b0;
    assign mem_wdata = '0;
    assign unused_ok = ^{proc_write, proc_wdata};
    // next state and handshake outputs; the refill always targets the latched mem_addr
    always_comb begin
        miss = proc_read && !hit;
        fill = (state_q == ALLOCATE) && mem_ready;
        mem_read = state_q == ALLOCATE;
        proc_stall = mem_read || miss;
        state_d = state_q == IDLE ? (miss ? ALLOCATE : IDLE) : (mem_ready ? IDLE : ALLOCATE);
    end
    // state, valid bits and refill address; reset abandons any in-flight refill
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            valid_q <= '0;
            mem_addr <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && miss) mem_addr <= proc_addr[29:2];
            if (fill) valid_q[fill_idx] <= 1'b1;
        end
    end
    // tag and data arrays are only meaningful under their valid bit, so they are not reset
    always_ff @(posedge clk) begin
        if (fill) begin
            tag_q[fill_idx] <= mem_addr[27:INDEX_W];
            data_q[fill_idx] <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_icache_dm_readonly.sv
// tb_icache_dm_readonly: directed and random fetches against a line-presence reference model
module tb_icache_dm_readonly;
    logic clk = 1'b0;
    logic rst;
    logic proc_read, proc_write, proc_stall;
    logic [29:0] proc_addr;
    logic [31:0] proc_wdata, proc_rdata;
    logic mem_read, mem_write, mem_ready;
    logic [27:0] mem_addr;
    logic [127:0] mem_wdata, mem_rdata;
    int checks = 0;
    int errors = 0;
    bit m_busy;
    logic [27:0] m_addr;
    bit m_valid [8];
    logic [24:0] m_tag [8];

    icache_dm_readonly dut (
        .clk(clk), .rst(rst),
        .proc_read(proc_read), .proc_write(proc_write), .proc_addr(proc_addr),
        .proc_wdata(proc_wdata), .proc_stall(proc_stall), .proc_rdata(proc_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [29:0] wa);
        return ({2'b00, wa} * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    function automatic logic [127:0] mem_line(input logic [27:0] la);
        return {mem_word({la, 2'd3}), mem_word({la, 2'd2}), mem_word({la, 2'd1}), mem_word({la, 2'd0})};
    endfunction

    function automatic bit m_hit(input logic [29:0] a);
        return m_valid[a[4:2]] && m_tag[a[4:2]] == a[29:5];
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0;
        m_addr = '0;
        foreach (m_valid[i]) m_valid[i] = 0;
    endtask

    // one clock: check outputs against the model mid-cycle, then advance the model at the edge
    task automatic step();
        bit h;
        if (mem_ready) mem_rdata = m_busy ? mem_line(m_addr) : {$urandom, $urandom, $urandom, $urandom};
        #1;
        h = m_hit(proc_addr);
        check("stall", proc_stall, m_busy | (proc_read & ~h));
        check("mem_read", mem_read, m_busy);
        if (m_busy) check("mem_addr", mem_addr, m_addr);
        if (h) check("rdata", proc_rdata, mem_word(proc_addr));
        check("mem_write", mem_write, 0);
        check("mem_wdata", mem_wdata, 0);
        @(posedge clk);
        if (!m_busy && proc_read && !h) begin
            m_busy = 1;
            m_addr = proc_addr[29:2];
        end else if (m_busy && mem_ready) begin
            m_valid[m_addr[2:0]] = 1;
            m_tag[m_addr[2:0]] = m_addr[27:3];
            m_busy = 0;
        end
        #1;
        mem_ready = 0;
    endtask

    task automatic fetch(input logic [29:0] a, input int n);
        proc_read = 1;
        proc_addr = a;
        step();
        repeat (n) step();
        mem_ready = 1;
        step();
        step();
    endtask

    initial begin
        rst = 1;
        proc_read = 1;
        proc_write = 0;
        proc_addr = '0;
        proc_wdata = '0;
        mem_ready = 0;
        mem_rdata = '0;
        model_reset();
        #3;
        check("reset_stall", proc_stall, 1);
        check("reset_mem_read", mem_read, 0);
        check("reset_mem_addr", mem_addr, 0);
        @(posedge clk);
        #1;
        rst = 0;
        fetch(30'h0, 3);
        proc_addr = 30'h1;
        step();
        fetch(30'h20, 2);
        fetch(30'h0, 1);
        proc_read = 1;
        proc_addr = 30'h4;
        step();
        step();
        proc_read = 0;
        proc_addr = 30'h40;
        step();
        step();
        mem_ready = 1;
        step();
        proc_read = 1;
        proc_addr = 30'h4;
        step();
        fetch(30'h40, 2);
        proc_addr = 30'h8;
        step();
        step();
        #2;
        rst = 1;
        #1;
        check("rst_async_mem_read", mem_read, 0);
        check("rst_async_stall", proc_stall, proc_read);
        check("rst_async_mem_addr", mem_addr, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 0;
        fetch(30'h8, 2);
        fetch(30'h3, 0);
        proc_write = 1;
        proc_wdata = 32'hDEADBEEF;
        repeat (3) step();
        proc_write = 0;
        step();
        proc_read = 0;
        repeat (3) begin
            mem_ready = 1;
            step();
        end
        proc_read = 1;
        foreach (m_valid[i]) begin
            proc_addr = 30'(i * 4 + 2);
            step();
            proc_addr = 30'h8 + 30'(i % 4);
            step();
        end
        for (int i = 0; i < 3000; i++) begin
            proc_read = ($urandom % 8) != 0;
            proc_addr = 30'((($urandom % 4) << 5) | ($urandom % 32));
            proc_write = ($urandom % 6) == 0;
            proc_wdata = $urandom;
            mem_ready = m_busy ? (($urandom % 3) == 0) : (($urandom % 12) == 0);
            step();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
